// File: rtl/vga_timing_gen.sv
// Raster timing source for the 1024x768@60 video pipeline: counters, syncs, blanks, frame strobe.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HB_START = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VB_START = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        wrap;
    logic        hblnk_next;
    logic        vblnk_next;
    logic        hsync_next;
    logic        vsync_next;

    // Flags are decoded from the next counter values so they register alongside them.
    always_comb begin
        h_next = hcount + 11'd1;
        v_next = vcount;
        wrap   = 1'b0;
        if (hcount == H_LAST) begin
            h_next = '0;
            if (vcount == V_LAST) begin
                v_next = '0;
                wrap   = 1'b1;
            end else begin
                v_next = vcount + 11'd1;
            end
        end
        hblnk_next = (h_next >= HB_START);
        vblnk_next = (v_next >= VB_START);
        hsync_next = (h_next >= HS_START && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_next = (v_next >= VS_START && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= hblnk_next;
            vblnk       <= vblnk_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            frame_start <= wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pix_en && wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-geometry instance for line timing, reduced-geometry instance
// (16x10 totals, active-low syncs) for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default instance
    logic        rst_d, en_d;
    logic [10:0] hc_d, vc_d;
    logic        hs_d, vs_d, hb_d, vb_d, fs_d;
    logic [15:0] fc_d;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst_d), .pix_en(en_d),
        .vcount(vc_d), .vsync(vs_d), .vblnk(vb_d),
        .hcount(hc_d), .hsync(hs_d), .hblnk(hb_d),
        .frame_start(fs_d), .frame_cnt(fc_d)
    );

    // small instance: H 8+2+3+3=16 (hsync 10..12), V 6+1+2+1=10 (vsync 7..8), frame=160 edges
    logic        rst_s, en_s;
    logic [10:0] hc_s, vc_s;
    logic        hs_s, vs_s, hb_s, vb_s, fs_s;
    logic [15:0] fc_s;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst(rst_s), .pix_en(en_s),
        .vcount(vc_s), .vsync(vs_s), .vblnk(vb_s),
        .hcount(hc_s), .hsync(hs_s), .hblnk(hb_s),
        .frame_start(fs_s), .frame_cnt(fc_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_d = 1'b1; en_d = 1'b1; rst_s = 1'b1; en_s = 1'b1;
        steps(3);
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd0) begin
            errors++; $display("FAIL reset_cnt_d: got h=%0d v=%0d want 0 0", hc_d, vc_d);
        end
        checks++;
        if ({hb_d, vb_d, hs_d, vs_d, fs_d} !== 5'b00000 || fc_d !== 16'd0) begin
            errors++; $display("FAIL reset_flags_d: got hb vb hs vs fs=%b fc=%0d want 00000 0",
                               {hb_d, vb_d, hs_d, vs_d, fs_d}, fc_d);
        end
        checks++;
        if (hc_s !== 11'd0 || vc_s !== 11'd0 || {hb_s, vb_s, hs_s, vs_s, fs_s} !== 5'b00110) begin
            errors++; $display("FAIL reset_small: got h=%0d v=%0d flags=%b want 0 0 00110",
                               hc_s, vc_s, {hb_s, vb_s, hs_s, vs_s, fs_s});
        end
        // rst has priority over pix_en (still enabled above); release now
        rst_d = 1'b0;
    endtask

    task automatic test_line();
        int hs_cnt, hs_first, hs_last, bad;
        step();
        checks++;
        if (hc_d !== 11'd1 || vc_d !== 11'd0 || hb_d !== 1'b0 || fs_d !== 1'b0) begin
            errors++; $display("FAIL first_edge: got h=%0d v=%0d hb=%b fs=%b want 1 0 0 0", hc_d, vc_d, hb_d, fs_d);
        end
        steps(1022);
        checks++;
        if (hc_d !== 11'd1023 || hb_d !== 1'b0) begin
            errors++; $display("FAIL h1023: got h=%0d hb=%b want 1023 0", hc_d, hb_d);
        end
        step();
        checks++;
        if (hc_d !== 11'd1024 || hb_d !== 1'b1) begin
            errors++; $display("FAIL h1024: got h=%0d hb=%b want 1024 1", hc_d, hb_d);
        end
        hs_cnt = 0; hs_first = -1; hs_last = -1; bad = 0;
        for (int n = 1025; n <= 1343; n++) begin
            step();
            if (hc_d !== 11'(n) || hb_d !== 1'b1 || vc_d !== 11'd0) bad++;
            if (hs_d === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = n;
                hs_last = n;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hblank_run: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (hs_cnt != 136 || hs_first != 1048 || hs_last != 1183) begin
            errors++; $display("FAIL hsync_window: got cnt=%0d first=%0d last=%0d want 136 1048 1183",
                               hs_cnt, hs_first, hs_last);
        end
        step();
        checks++;
        if (hc_d !== 11'd0 || vc_d !== 11'd1 || hb_d !== 1'b0 || hs_d !== 1'b0 || vb_d !== 1'b0) begin
            errors++; $display("FAIL line_wrap: got h=%0d v=%0d hb=%b hs=%b vb=%b want 0 1 0 0 0",
                               hc_d, vc_d, hb_d, hs_d, vb_d);
        end
    endtask

    task automatic test_stall_line();
        int bad;
        rst_d = 1'b1; step(); rst_d = 1'b0;
        steps(500);
        en_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (hc_d !== 11'd500 || vc_d !== 11'd0 || {hb_d, vb_d, hs_d, vs_d, fs_d} !== 5'b00000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold: got %0d bad cycles (h=%0d) want 0 (h=500)", bad, hc_d);
        end
        en_d = 1'b1;
        step();
        checks++;
        if (hc_d !== 11'd501) begin
            errors++; $display("FAIL stall_resume: got h=%0d want 501", hc_d);
        end
    endtask

    task automatic test_frame();
        int bad, first_fs;
        logic eh, ev, ehb, evb, ehs, evs, efs;
        rst_s = 1'b1; en_s = 1'b1; step(); rst_s = 1'b0;
        bad = 0; first_fs = -1;
        for (int n = 1; n <= 161; n++) begin
            int h, v;
            step();
            h = n % 16; v = (n / 16) % 10;
            ehb = (h >= 8);
            evb = (v >= 6);
            ehs = (h >= 10 && h <= 12) ? 1'b0 : 1'b1;
            evs = (v >= 7 && v <= 8) ? 1'b0 : 1'b1;
            efs = (n == 160);
            eh = (hc_s === 11'(h));
            ev = (vc_s === 11'(v));
            if (fs_s === 1'b1 && first_fs < 0) first_fs = n;
            checks++;
            if (!eh || !ev || hb_s !== ehb || vb_s !== evb || hs_s !== ehs || vs_s !== evs || fs_s !== efs) begin
                errors++; bad++;
                $display("FAIL frame_edge%0d: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b fs=%b want %0d %0d %b %b %b %b %b",
                         n, hc_s, vc_s, hb_s, vb_s, hs_s, vs_s, fs_s, h, v, ehb, evb, ehs, evs, efs);
            end
        end
        checks++;
        if (first_fs != 160) begin
            errors++; $display("FAIL first_strobe: got edge %0d want 160", first_fs);
        end
    endtask

    task automatic test_stall_frame();
        int bad;
        rst_s = 1'b1; step(); rst_s = 1'b0;
        steps(160);
        checks++;
        if (fs_s !== 1'b1 || hc_s !== 11'd0 || vc_s !== 11'd0) begin
            errors++; $display("FAIL strobe_pre_stall: got fs=%b h=%0d v=%0d want 1 0 0", fs_s, hc_s, vc_s);
        end
        en_s = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fs_s !== 1'b0 || hc_s !== 11'd0 || vc_s !== 11'd0 || hs_s !== 1'b1 || vs_s !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL strobe_stall: got %0d bad cycles fs=%b want 0 (fs=0)", bad, fs_s);
        end
        en_s = 1'b1;
        step();
        checks++;
        if (hc_s !== 11'd1 || fs_s !== 1'b0) begin
            errors++; $display("FAIL strobe_resume: got h=%0d fs=%b want 1 0", hc_s, fs_s);
        end
    endtask

    task automatic test_reset_mid();
        int early;
        rst_s = 1'b1; step(); rst_s = 1'b0;
        steps(69);
        checks++;
        if (hc_s !== 11'd5 || vc_s !== 11'd4) begin
            errors++; $display("FAIL mid_pos: got h=%0d v=%0d want 5 4", hc_s, vc_s);
        end
        rst_s = 1'b1; step(); rst_s = 1'b0;
        checks++;
        if (hc_s !== 11'd0 || vc_s !== 11'd0 || {hb_s, vb_s, hs_s, vs_s, fs_s} !== 5'b00110) begin
            errors++; $display("FAIL mid_reset: got h=%0d v=%0d flags=%b want 0 0 00110",
                               hc_s, vc_s, {hb_s, vb_s, hs_s, vs_s, fs_s});
        end
        early = 0;
        for (int i = 0; i < 159; i++) begin
            step();
            if (fs_s !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL mid_early_strobe: got %0d strobes want 0", early);
        end
        step();
        checks++;
        if (fs_s !== 1'b1) begin
            errors++; $display("FAIL mid_full_frame: got fs=%b want 1", fs_s);
        end
    endtask

    task automatic test_frame_cnt();
        logic [15:0] exp3;
        int nz;
`ifdef VGA_TIMING_FRAME_CNT_EN
        exp3 = 16'd3;
`else
        exp3 = 16'd0;
`endif
        rst_s = 1'b1; step(); rst_s = 1'b0;
        checks++;
        if (fc_s !== 16'd0) begin
            errors++; $display("FAIL fc_reset: got %0d want 0", fc_s);
        end
        nz = 0;
        for (int i = 0; i < 480; i++) begin
            step();
            if (fc_s !== 16'd0) nz++;
        end
        checks++;
        if (fc_s !== exp3) begin
            errors++; $display("FAIL fc_three: got %0d want %0d", fc_s, exp3);
        end
`ifndef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (nz != 0) begin
            errors++; $display("FAIL fc_tied: got %0d nonzero cycles want 0", nz);
        end
`endif
        en_s = 1'b0; steps(4); en_s = 1'b1;
        checks++;
        if (fc_s !== exp3) begin
            errors++; $display("FAIL fc_hold: got %0d want %0d", fc_s, exp3);
        end
        rst_s = 1'b1; step(); rst_s = 1'b0;
        checks++;
        if (fc_s !== 16'd0) begin
            errors++; $display("FAIL fc_clear: got %0d want 0", fc_s);
        end
    endtask

    initial begin
        rst_d = 1'b1; en_d = 1'b0; rst_s = 1'b1; en_s = 1'b0;
        #1;
        test_reset();
        rst_s = 1'b0;
        test_line();
        test_stall_line();
        test_frame();
        test_stall_frame();
        test_reset_mid();
        test_frame_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
